// File: rtl/processor_pkg.sv
// Shared datapath definitions: default data width, reset value and a
// constant-foldable clog2 used to size address ports.
package processor_pkg;

    localparam int          DEFAULT_WIDTH     = 32'd8;
    localparam logic [63:0] DEFAULT_RESET_VAL = 64'h0;

    // Smallest r with 2**r >= n, never less than 1 so every address port has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 32'd1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 32'd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One asynchronous read port of reg_file: range check, zero-entry masking and,
// when REG_FILE_BYPASS_EN is defined, same-cycle write-through forwarding.
module reg_file_read_port
    import processor_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] i_mem,
    input  logic [AW-1:0]               i_raddr,
`ifdef REG_FILE_BYPASS_EN
    input  logic                        i_wr_fire,
    input  logic [AW-1:0]               i_waddr,
    input  logic [WIDTH-1:0]            i_wdata,
`endif
    output logic [WIDTH-1:0]            o_rdata
);

    localparam logic [AW:0] L_DEPTH = DEPTH[AW:0];
    localparam bit          L_ZERO  = (ZERO_REG != 0);

    logic w_in_range;
    logic w_is_zero;

    assign w_in_range = ({1'b0, i_raddr} < L_DEPTH);
    assign w_is_zero  = L_ZERO && (i_raddr == '0);

    // Read mux; an in-range, non-zero match on the write address implies the write is legal.
    always_comb begin
        o_rdata = '0;
        if (!w_in_range) begin
            o_rdata = '0;
        end else if (w_is_zero) begin
            o_rdata = '0;
`ifdef REG_FILE_BYPASS_EN
        end else if (i_wr_fire && (i_waddr == i_raddr)) begin
            o_rdata = i_wdata;
`endif
        end else begin
            o_rdata = i_mem[i_raddr];
        end
    end

endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file, one synchronous write port, two combinational
// read ports. Define REG_FILE_BYPASS_EN for write-through forwarding to reads.
module reg_file
    import processor_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = 8,
    parameter int               ZERO_REG  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = DEFAULT_RESET_VAL[WIDTH-1:0],
    localparam int              AW        = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    localparam logic [AW:0] L_DEPTH = DEPTH[AW:0];
    localparam bit          L_ZERO  = (ZERO_REG != 0);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic                        w_wr_fire;
    logic                        w_wr_ok;

    assign w_wr_fire = ce && we && !rst;
    assign w_wr_ok   = ce && we
                       && ({1'b0, waddr} < L_DEPTH)
                       && !(L_ZERO && (waddr == '0));

    // Storage update: reset wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
            if (L_ZERO) begin
                r_mem[0] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    reg_file_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_port_a (
        .i_mem     (r_mem),
        .i_raddr   (raddr_a),
`ifdef REG_FILE_BYPASS_EN
        .i_wr_fire (w_wr_fire),
        .i_waddr   (waddr),
        .i_wdata   (wdata),
`endif
        .o_rdata   (rdata_a)
    );

    reg_file_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_port_b (
        .i_mem     (r_mem),
        .i_raddr   (raddr_b),
`ifdef REG_FILE_BYPASS_EN
        .i_wr_fire (w_wr_fire),
        .i_waddr   (waddr),
        .i_wdata   (wdata),
`endif
        .o_rdata   (rdata_b)
    );

`ifndef REG_FILE_BYPASS_EN
    logic w_unused;
    assign w_unused = w_wr_fire;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a default 8-entry instance and a
// 6-entry ZERO_REG instance with a non-zero reset value share one stimulus.
module tb_reg_file;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic [7:0] rd_a0, rd_b0, rd_a1, rd_b1;

    int checks = 0;
    int errors = 0;

    // Reference contents: m0 for the 8-entry instance, m1 for the 6-entry one.
    logic [7:0] m0 [8];
    logic [7:0] m1 [8];

    localparam logic [7:0] RV1 = 8'hC3;

    reg_file u_dut0 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a0), .raddr_b(raddr_b), .rdata_b(rd_b0)
    );

    reg_file #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1), .RESET_VAL(8'hC3)) u_dut1 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a1), .raddr_b(raddr_b), .rdata_b(rd_b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] exp_rd(input int inst, input int addr);
        int depth;
        depth = (inst == 1) ? 6 : 8;
        if (addr >= depth) return 8'h00;
        if (inst == 1 && addr == 0) return 8'h00;
`ifdef REG_FILE_BYPASS_EN
        if (ce && we && !rst && int'(waddr) == addr) return wdata;
`endif
        return (inst == 1) ? m1[addr] : m0[addr];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-cycle, then compare all four read ports against the model.
    task automatic drive(input logic r, input logic c, input logic w, input logic [2:0] wa,
                         input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb,
                         input string tag);
        @(negedge clk);
        rst = r; ce = c; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
        #1;
        chk({tag, "/a0"}, rd_a0, exp_rd(0, int'(ra)));
        chk({tag, "/b0"}, rd_b0, exp_rd(0, int'(rb)));
        chk({tag, "/a1"}, rd_a1, exp_rd(1, int'(ra)));
        chk({tag, "/b1"}, rd_b1, exp_rd(1, int'(rb)));
    endtask

    task automatic commit();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m0[i] = 8'h00;
                m1[i] = (i == 0) ? 8'h00 : RV1;
            end
        end else if (ce && we) begin
            m0[waddr] = wdata;
            if (waddr < 3'd6 && waddr != 3'd0) m1[waddr] = wdata;
        end
    endtask

    task automatic step(input logic r, input logic c, input logic w, input logic [2:0] wa,
                        input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb,
                        input string tag);
        drive(r, c, w, wa, wd, ra, rb, tag);
        commit();
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 8'h00;
        raddr_a = 3'd0; raddr_b = 3'd0;
        for (int i = 0; i < 8; i++) begin
            m0[i] = 8'h00;
            m1[i] = 8'h00;
        end
        // First edge only establishes state; reads are not compared before it.
        @(negedge clk);
        commit();

        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), "rst_state");
            chk("rst_state_const0", rd_a0, 8'h00);
            chk("rst_state_const1", rd_a1, (i == 0 || i >= 6) ? 8'h00 : 8'hC3);
            commit();
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 3'(i), 8'h5A, 3'(i), 3'(i), "fill5a");
        end
        // Reset coincident with a write: the write must be lost.
        step(1'b1, 1'b1, 1'b1, 3'd1, 8'h99, 3'd1, 3'd2, "rst_vs_wr");
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'(i), 3'(i), "after_rst");
            chk("after_rst_const", rd_b0, 8'h00);
            commit();
        end

        step(1'b0, 1'b1, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd4, "wr3");
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd4, "rd3");
        chk("rd3_const", rd_a0, 8'hA5);
        chk("rd4_const", rd_b0, 8'h00);
        commit();

        step(1'b0, 1'b1, 1'b1, 3'd2, 8'h42, 3'd2, 3'd2, "wr2");
        step(1'b0, 1'b0, 1'b1, 3'd2, 8'hFF, 3'd2, 3'd2, "ce0");
        step(1'b0, 1'b1, 1'b0, 3'd2, 8'hFF, 3'd2, 3'd2, "we0");
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2, "rd2");
        chk("gate_const", rd_a0, 8'h42);
        commit();

        step(1'b0, 1'b1, 1'b1, 3'd0, 8'h77, 3'd0, 3'd0, "wr0");
        step(1'b0, 1'b1, 1'b1, 3'd7, 8'hEE, 3'd0, 3'd7, "wr7");
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd7, "rd07");
        chk("zero_const", rd_a1, 8'h00);
        chk("oor_const", rd_b1, 8'h00);
        chk("wr0_d0_const", rd_a0, 8'h77);
        commit();

        step(1'b0, 1'b1, 1'b1, 3'd5, 8'h11, 3'd0, 3'd5, "wr5_old");
        drive(1'b0, 1'b1, 1'b1, 3'd5, 8'h3C, 3'd0, 3'd5, "collide");
`ifdef REG_FILE_BYPASS_EN
        chk("collide_const", rd_b0, 8'h3C);
`else
        chk("collide_const", rd_b0, 8'h11);
`endif
        commit();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd5, "after_collide");
        chk("after_collide_const", rd_b0, 8'h3C);
        commit();

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(31) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(7)), 8'($urandom_range(255)),
                 3'($urandom_range(7)), 3'($urandom_range(7)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
